// File: rtl/hex_display_pkg.sv
// Shared constants for the DE10-Lite seven-segment bank: active-low glyphs
// (bit7 = dp, bits6..0 = g..a) and the message-select codes.
package hex_display_pkg;

  localparam logic [7:0] GLYPH_A     = 8'b10001000;
  localparam logic [7:0] GLYPH_K     = 8'b10001001;
  localparam logic [7:0] GLYPH_L     = 8'b11000111;
  localparam logic [7:0] GLYPH_M     = 8'b11101010;
  localparam logic [7:0] GLYPH_N     = 8'b10101011;
  localparam logic [7:0] GLYPH_O     = 8'b11000000;
  localparam logic [7:0] GLYPH_S     = 8'b10010010;
  localparam logic [7:0] GLYPH_T     = 8'b10000111;
  localparam logic [7:0] GLYPH_Y     = 8'b10010001;
  localparam logic [7:0] GLYPH_BLANK = 8'b11111111;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_ASTANA = 2'b01;
  localparam logic [1:0] SEL_NSK    = 2'b10;
  localparam logic [1:0] SEL_TOMSK  = 2'b11;

  localparam int MAX_MSG_LEN = 6;

  // The virtual stream starts with one full bank of blanks before the message.
  localparam logic [3:0] LEAD_BLANKS = 4'(MAX_MSG_LEN);

endpackage

// File: rtl/hex_message_rom.sv
// Glyph lookup into the virtual scroll stream of the selected city message,
// plus that message's length.
module hex_message_rom
  import hex_display_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] index,
  output logic [7:0] glyph,
  output logic [2:0] len
);

  logic [3:0] pos;

  assign pos = index - LEAD_BLANKS;

  // Length of the selected message.
  always_comb begin
    case (sel)
      SEL_TOMSK:  len = 3'd5;
      SEL_NSK:    len = 3'd3;
      SEL_ASTANA: len = 3'd6;
      default:    len = 3'd0;
    endcase
  end

  // Glyph at a stream index: leading blanks, the message, then trailing blanks.
  always_comb begin
    glyph = GLYPH_BLANK;
    if ((index < LEAD_BLANKS) || (pos >= {1'b0, len})) begin
      glyph = GLYPH_BLANK;
    end else begin
      case ({sel, pos[2:0]})
        {SEL_TOMSK, 3'd0}:  glyph = GLYPH_T;
        {SEL_TOMSK, 3'd1}:  glyph = GLYPH_O;
        {SEL_TOMSK, 3'd2}:  glyph = GLYPH_M;
        {SEL_TOMSK, 3'd3}:  glyph = GLYPH_S;
        {SEL_TOMSK, 3'd4}:  glyph = GLYPH_K;
        {SEL_NSK, 3'd0}:    glyph = GLYPH_N;
        {SEL_NSK, 3'd1}:    glyph = GLYPH_S;
        {SEL_NSK, 3'd2}:    glyph = GLYPH_K;
        {SEL_ASTANA, 3'd0}: glyph = GLYPH_A;
        {SEL_ASTANA, 3'd1}: glyph = GLYPH_S;
        {SEL_ASTANA, 3'd2}: glyph = GLYPH_T;
        {SEL_ASTANA, 3'd3}: glyph = GLYPH_A;
        {SEL_ASTANA, 3'd4}: glyph = GLYPH_N;
        {SEL_ASTANA, 3'd5}: glyph = GLYPH_A;
        default:            glyph = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/hex_scroll_controller.sv
// Debounces the two push-buttons into a city selection and scrolls that city
// right-to-left across hex5..hex0, pausing while it sits right-aligned.
module hex_scroll_controller
  import hex_display_pkg::*;
#(
  parameter int STEP_CYCLES     = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PAUSE_STEPS     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] key,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(PAUSE_STEPS + 1);

  localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PAUSE_DONE = PW'(PAUSE_STEPS);

  localparam logic [1:0] ST_BLANK  = 2'd0;
  localparam logic [1:0] ST_SCROLL = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;

  logic [1:0]    sync1, sync2, cand, sel;
  logic [DW-1:0] deb_cnt, deb_next;
  logic          sel_change;

  logic [1:0]    state;
  logic [3:0]    p;
  logic [TW-1:0] timer;
  logic [PW-1:0] pause_cnt;
  logic          step;
  logic [2:0]    len;
  logic [3:0]    len_end;
  logic          len_agree;

  logic [7:0]    glyphs [6];
  logic [2:0]    lens   [6];

  // Debounce counter: restarts on any change of the synced value, saturates once stable.
  always_comb begin
    if (sync2 != cand) begin
      deb_next = {DW{1'b0}};
    end else if (deb_cnt == DEB_LAST) begin
      deb_next = deb_cnt;
    end else begin
      deb_next = deb_cnt + DW'(1'b1);
    end
  end

  assign sel_change = (sync2 == cand) && (deb_next == DEB_LAST) && (cand != sel);

  // Key synchronizer, debounce candidate and accepted selection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      cand    <= 2'b11;
      deb_cnt <= {DW{1'b0}};
      sel     <= SEL_TOMSK;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      cand    <= sync2;
      deb_cnt <= deb_next;
      sel     <= sel_change ? cand : sel;
    end
  end

  // Digit k shows stream[p + 5 - k]; indices past the stream clamp onto a blank slot.
  for (genvar k = 0; k < 6; k++) begin : g_digit
    logic [4:0] idx_wide;
    logic [3:0] idx;
    assign idx_wide = {1'b0, p} + 5'(5 - k);
    assign idx      = idx_wide[4] ? 4'd15 : idx_wide[3:0];
    hex_message_rom u_rom (
      .sel   (sel),
      .index (idx),
      .glyph (glyphs[k]),
      .len   (lens[k])
    );
  end

  // All digit lookups see the same sel, so a length disagreement means a broken lookup.
  always_comb begin
    len_agree = 1'b1;
    for (int k = 1; k < 6; k++) begin
      if (lens[k] != lens[0]) begin
        len_agree = 1'b0;
      end else begin
        len_agree = len_agree;
      end
    end
  end

  assign len     = lens[0];
  assign len_end = {1'b0, len} + 4'd5;
  assign step    = (timer == STEP_LAST);

  // Scroll position, step timer and pause sequencing; a new selection restarts everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_SCROLL;
      p         <= 4'd0;
      timer     <= {TW{1'b0}};
      pause_cnt <= {PW{1'b0}};
    end else if (sel_change) begin
      state     <= (cand == SEL_NONE) ? ST_BLANK : ST_SCROLL;
      p         <= 4'd0;
      timer     <= {TW{1'b0}};
      pause_cnt <= {PW{1'b0}};
    end else begin
      case (state)
        ST_BLANK: begin
          p         <= 4'd0;
          timer     <= {TW{1'b0}};
          pause_cnt <= {PW{1'b0}};
        end
        ST_SCROLL: begin
          timer <= step ? {TW{1'b0}} : timer + TW'(1'b1);
          if (step) begin
            if (p == {1'b0, len}) begin
              state     <= ST_PAUSE;
              pause_cnt <= {PW{1'b0}};
            end else if (p == len_end) begin
              p <= 4'd0;
            end else begin
              p <= p + 4'd1;
            end
          end
        end
        ST_PAUSE: begin
          timer <= step ? {TW{1'b0}} : timer + TW'(1'b1);
          if (step) begin
            if ((pause_cnt + PW'(1'b1)) == PAUSE_DONE) begin
              p         <= {1'b0, len} + 4'd1;
              state     <= ST_SCROLL;
              pause_cnt <= {PW{1'b0}};
            end else begin
              pause_cnt <= pause_cnt + PW'(1'b1);
            end
          end
        end
        default: begin
          state     <= ST_SCROLL;
          p         <= 4'd0;
          timer     <= {TW{1'b0}};
          pause_cnt <= {PW{1'b0}};
        end
      endcase
    end
  end

  // Segment outputs follow (sel, p) one cycle later.
  always_ff @(posedge clock) begin
    if (reset || !len_agree) begin
      hex0 <= GLYPH_BLANK;
      hex1 <= GLYPH_BLANK;
      hex2 <= GLYPH_BLANK;
      hex3 <= GLYPH_BLANK;
      hex4 <= GLYPH_BLANK;
      hex5 <= GLYPH_BLANK;
    end else begin
      hex0 <= glyphs[0];
      hex1 <= glyphs[1];
      hex2 <= glyphs[2];
      hex3 <= glyphs[3];
      hex4 <= glyphs[4];
      hex5 <= glyphs[5];
    end
  end

endmodule

// File: tb/tb_hex_scroll_controller.sv
// Table-driven bench for hex_scroll_controller with a queue scoreboard of
// expected {hex5..hex0} frames; timings use STEP=4, DEBOUNCE=3, PAUSE=2.
module tb_hex_scroll_controller;

  logic       clock;
  logic       reset;
  logic [1:0] key;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int assertions = 0;
  int failures   = 0;

  logic [47:0] exp_q [$];

  typedef struct {
    logic [1:0]  key;
    int          cycles;
    logic        every;
    logic [47:0] frame;
    string       name;
  } vec_t;

  vec_t vecs [$];

  localparam logic [47:0] ALL_FF   = {6{8'hFF}};
  localparam logic [47:0] T_FIRST  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h87};
  localparam logic [47:0] TOMSK_R  = {8'hFF, 8'h87, 8'hC0, 8'hEA, 8'h92, 8'h89};
  localparam logic [47:0] TOMSK_L1 = {8'h87, 8'hC0, 8'hEA, 8'h92, 8'h89, 8'hFF};
  localparam logic [47:0] TOMSK_K  = {8'h89, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [47:0] TOMSK_P3 = {8'hFF, 8'hFF, 8'hFF, 8'h87, 8'hC0, 8'hEA};
  localparam logic [47:0] TOMSK_P4 = {8'hFF, 8'hFF, 8'h87, 8'hC0, 8'hEA, 8'h92};
  localparam logic [47:0] N_FIRST  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAB};
  localparam logic [47:0] NSK_R    = {8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'h92, 8'h89};
  localparam logic [47:0] NSK_L1   = {8'hFF, 8'hFF, 8'hAB, 8'h92, 8'h89, 8'hFF};
  localparam logic [47:0] AST_R    = {8'h88, 8'h92, 8'h87, 8'h88, 8'hAB, 8'h88};
  localparam logic [47:0] AST_L1   = {8'h92, 8'h87, 8'h88, 8'hAB, 8'h88, 8'hFF};

  hex_scroll_controller #(
    .STEP_CYCLES     (4),
    .DEBOUNCE_CYCLES (3),
    .PAUSE_STEPS     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .hex0  (hex0),
    .hex1  (hex1),
    .hex2  (hex2),
    .hex3  (hex3),
    .hex4  (hex4),
    .hex5  (hex5)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name);
    logic [47:0] got;
    logic [47:0] want;
    got = {hex5, hex4, hex3, hex2, hex1, hex0};
    assertions++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL %s: got %h expected %h", name, got, want);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    key = v.key;
    if (v.every) begin
      for (int i = 0; i < v.cycles; i++) exp_q.push_back(v.frame);
    end else begin
      exp_q.push_back(v.frame);
    end
    for (int i = 1; i <= v.cycles; i++) begin
      @(posedge clock);
      #1;
      if (v.every || (i == v.cycles)) check(v.name);
    end
  endtask

  initial begin
    vecs.push_back('{2'b11,  4, 1'b0, ALL_FF,   "tomsk_lead_blank"});
    vecs.push_back('{2'b11,  1, 1'b0, T_FIRST,  "tomsk_first_T"});
    vecs.push_back('{2'b11, 16, 1'b0, TOMSK_R,  "tomsk_right_aligned"});
    vecs.push_back('{2'b11, 11, 1'b1, TOMSK_R,  "tomsk_pause_hold"});
    vecs.push_back('{2'b11,  1, 1'b0, TOMSK_L1, "tomsk_leave_pause"});
    vecs.push_back('{2'b11, 16, 1'b0, TOMSK_K,  "tomsk_last_K"});
    vecs.push_back('{2'b11,  4, 1'b0, ALL_FF,   "tomsk_wrap"});
    vecs.push_back('{2'b10,  2, 1'b0, ALL_FF,   "glitch_on"});
    vecs.push_back('{2'b11,  2, 1'b0, T_FIRST,  "glitch_ignored"});
    vecs.push_back('{2'b11,  8, 1'b0, TOMSK_P3, "tomsk_p3"});
    vecs.push_back('{2'b10,  6, 1'b0, ALL_FF,   "nsk_select"});
    vecs.push_back('{2'b10,  4, 1'b0, N_FIRST,  "nsk_first_N"});
    vecs.push_back('{2'b10,  8, 1'b0, NSK_R,    "nsk_right_aligned"});
    vecs.push_back('{2'b10, 11, 1'b1, NSK_R,    "nsk_pause_hold"});
    vecs.push_back('{2'b10,  1, 1'b0, NSK_L1,   "nsk_leave_pause"});
    vecs.push_back('{2'b01,  6, 1'b0, ALL_FF,   "astana_select"});
    vecs.push_back('{2'b01, 24, 1'b0, AST_R,    "astana_full"});
    vecs.push_back('{2'b01, 11, 1'b1, AST_R,    "astana_pause_hold"});
    vecs.push_back('{2'b01,  1, 1'b0, AST_L1,   "astana_leave_pause"});
    vecs.push_back('{2'b00,  6, 1'b0, ALL_FF,   "none_select"});
    vecs.push_back('{2'b00, 40, 1'b1, ALL_FF,   "none_idle"});
    vecs.push_back('{2'b11,  6, 1'b0, ALL_FF,   "tomsk_reselect"});
    vecs.push_back('{2'b11,  4, 1'b0, T_FIRST,  "tomsk_restart"});
    vecs.push_back('{2'b11, 12, 1'b0, TOMSK_P4, "tomsk_p4"});
    vecs.push_back('{2'b11, 10, 1'b0, TOMSK_R,  "tomsk_in_pause"});

    // Reset state.
    reset = 1'b1;
    key   = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    exp_q.push_back(ALL_FF);
    check("reset_state");
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // One-cycle reset while TOMSK is paused, then a clean restart.
    reset = 1'b1;
    exp_q.push_back(ALL_FF);
    @(posedge clock);
    #1;
    check("reset_in_pause");
    reset = 1'b0;
    exp_q.push_back(ALL_FF);
    repeat (4) @(posedge clock);
    #1;
    check("post_reset_blank");
    exp_q.push_back(T_FIRST);
    @(posedge clock);
    #1;
    check("post_reset_first_T");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
